udma_apb_cfg_slave: RTL and testbench
=====================================

Name: udma_apb_cfg_slave

Overview:
- APB completer (slave) for the uDMA core configuration space: peripheral clock-gate register, set/clear aliases, and read-only peripheral-ID window.
- Terminates transactions from the SoC APB interconnect, inserts programmable wait states, and flags unmapped or illegal accesses with pslverr.
- Drives cg_o toward the per-peripheral clock gates.

Parameters:
- NUM_PERIPH, 8, number of peripherals; width of the clock-gate register, 1..32.
- WAIT_CYCLES, 0, extra access-phase cycles with pready low before completion, 0..15.
- ADDR_WIDTH, 12, number of paddr bits decoded; upper bits ignored.

Ports:
- clk_i  in  1  clock; everything is on the rising edge.
- rst_i  in  1  synchronous reset, active-high.
- paddr_i  in  32  APB address.
- pwdata_i  in  32  APB write data.
- pwrite_i  in  1  1 = write, 0 = read.
- psel_i  in  1  APB select.
- penable_i  in  1  APB enable, marks the access phase.
- prdata_o  out  32  read data; valid only while pready_o=1.
- pready_o  out  1  transfer complete.
- pslverr_o  out  1  error response; valid only while pready_o=1.
- cg_o  out  NUM_PERIPH  clock-gate enables; bit k = peripheral k.
- proto_err_o  out  1  sticky protocol-violation flag (feature only; tied 0 otherwise).

Behaviour:
- Interface: one clock; reset is synchronous and active-high (clk_i, rst_i).
- Reset values: prdata_o=0, pready_o=0, pslverr_o=0, cg_o=0, proto_err_o=0, FSM=IDLE, wait counter=0.
- Register map (byte offsets, word aligned; paddr[1:0] ignored):
  - 0x000 CG: RW, NUM_PERIPH bits; reads return zero-extended cg.
  - 0x004 CG_SET: WO; cg |= wdata[NUM_PERIPH-1:0]; reads return 0, no error.
  - 0x008 CG_CLR: WO; cg &= ~wdata; reads return 0, no error.
  - 0x080+4k, k<NUM_PERIPH: PERIPH_ID, RO; reads return k; a write gives pslverr=1 and no state change.
  - Any other address: pslverr=1, prdata=0, no state change.
- CG write data bits at or above NUM_PERIPH are ignored.
- FSM states IDLE, WAIT, RESP:
  - IDLE: when psel_i=1 and penable_i=0 (setup phase), latch paddr, pwrite, pwdata and decode.
    - WAIT_CYCLES=0: go to RESP.
    - Otherwise: load counter=WAIT_CYCLES-1 and go to WAIT.
  - WAIT: pready_o=0; decrement the counter; go to RESP when it reaches 0.
  - RESP: pready_o=1 for exactly one cycle, with prdata_o and pslverr_o valid.
    - A write commits at the clock edge ending the RESP cycle, only if psel_i and penable_i are both 1 and pslverr_o=0.
    - Then return to IDLE; pready_o, prdata_o and pslverr_o return to 0.
- Latency: with setup in cycle T0, pready_o=1 in cycle T1+WAIT_CYCLES.
- Back-to-back transfers: a setup phase in the cycle after RESP is accepted; no idle cycle required.
- Outputs are registered; no combinational path from APB inputs to pready_o, prdata_o or pslverr_o.
- Read data is decoded from the latched address in the setup cycle. A read of CG in the same transfer sequence as a preceding write returns the post-write value.
- psel_i deasserted during WAIT or RESP: abort to IDLE, no commit, pready_o=0 next cycle.
- Reset mid-transfer: immediately IDLE with all outputs at reset values; the in-flight write is discarded.
- cg_o changes only at a commit edge or on reset.

Optional Feature:
- Macro UDMA_APB_PROTO_CHECK_EN.
- Defined: proto_err_o is set, and held until rst_i, on any of:
  - penable_i=1 while psel_i=0;
  - penable_i=1 in the IDLE setup sample (no setup phase);
  - paddr_i, pwrite_i or pwdata_i differs from the latched value during WAIT or RESP while psel_i=1;
  - psel_i abort as described in Behaviour.
- Simulation builds also issue a $error on each violation.
- Not defined: no checker logic; proto_err_o tied to 0.

Test Plan:
- Reset, WAIT_CYCLES=0: write 0x000 data 0x0000_00A5 -> pready_o high in cycle T1, pslverr_o=0, cg_o=0xA5 after the commit edge; read 0x000 returns 0x0000_00A5.
- CG_SET 0x0000_0002, then CG_CLR 0x0000_0081 from cg=0xA5 -> cg_o=0xA7, then 0x26; reads of 0x004 and 0x008 return 0, pslverr_o=0.
- Read 0x08C (k=3) -> prdata_o=3; write 0x08C -> pslverr_o=1, cg_o unchanged; read 0x0A0 with NUM_PERIPH=8 -> pslverr_o=1, prdata_o=0.
- WAIT_CYCLES=3: read 0x000 -> pready_o low for 3 access cycles, high in cycle T4 for exactly one cycle; back-to-back second read completes at T9.
- Write 0x000 data 0xFF, then assert rst_i during WAIT -> cg_o=0 and pready_o=0 next cycle; a subsequent read of 0x000 returns 0.
- With UDMA_APB_PROTO_CHECK_EN: change paddr_i during WAIT -> proto_err_o=1 and stays 1 until rst_i; without the macro -> proto_err_o=0 throughout.

Source files
------------

// File: rtl/udma_apb_cfg_slave.sv
// rtl/udma_apb_cfg_slave.sv - uDMA config APB completer: clock-gate register, set/clear aliases, peripheral-ID window.
// Optional protocol checker enabled by UDMA_APB_PROTO_CHECK_EN.
module udma_apb_cfg_slave #(
  parameter int NUM_PERIPH  = 8,
  parameter int WAIT_CYCLES = 0,
  parameter int ADDR_WIDTH  = 12
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [31:0]           paddr_i,
  input  logic [31:0]           pwdata_i,
  input  logic                  pwrite_i,
  input  logic                  psel_i,
  input  logic                  penable_i,
  output logic [31:0]           prdata_o,
  output logic                  pready_o,
  output logic                  pslverr_o,
  output logic [NUM_PERIPH-1:0] cg_o,
  output logic                  proto_err_o
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t                r_state;
  state_t                w_next;
  logic [31:0]           r_addr;
  logic [31:0]           r_wdata;
  logic                  r_write;
  logic [3:0]            r_cnt;
  logic [3:0]            w_cnt_next;
  logic [NUM_PERIPH-1:0] r_cg;
  logic [31:0]           r_prdata;
  logic                  r_pready;
  logic                  r_pslverr;

  logic                  w_setup;
  logic [31:0]           w_dec_addr;
  logic                  w_dec_write;
  logic [31:0]           w_a;
  logic [31:0]           w_k;
  logic [31:0]           w_ca;
  logic [31:0]           w_rdata;
  logic                  w_err;
  logic                  w_commit;

  assign w_setup = (r_state == S_IDLE) && psel_i && !penable_i;

  // With no wait states the response is decoded straight from the setup-phase inputs.
  assign w_dec_addr  = (r_state == S_IDLE) ? paddr_i  : r_addr;
  assign w_dec_write = (r_state == S_IDLE) ? pwrite_i : r_write;
  assign w_a  = 32'({w_dec_addr[ADDR_WIDTH-1:2], 2'b00});
  assign w_k  = (w_a - 32'h80) >> 2;
  assign w_ca = 32'({r_addr[ADDR_WIDTH-1:2], 2'b00});

  always_comb begin
    w_rdata = '0;
    w_err   = 1'b0;
    if (w_a == 32'h0) begin
      w_rdata = 32'(r_cg);
    end else if (w_a == 32'h4 || w_a == 32'h8) begin
      w_rdata = '0;
    end else if (w_a >= 32'h80 && w_a < 32'h80 + 32'(4 * NUM_PERIPH)) begin
      if (w_dec_write) w_err = 1'b1;
      else             w_rdata = w_k;
    end else begin
      w_err = 1'b1;
    end
  end

  always_comb begin
    w_next     = r_state;
    w_cnt_next = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_setup) begin
          if (WAIT_CYCLES == 0) begin
            w_next = S_RESP;
          end else begin
            w_next     = S_WAIT;
            w_cnt_next = 4'(WAIT_CYCLES - 1);
          end
        end
      end
      S_WAIT: begin
        if (!psel_i)            w_next = S_IDLE;
        else if (r_cnt == 4'd0) w_next = S_RESP;
        else                    w_cnt_next = r_cnt - 4'd1;
      end
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  assign w_commit = (r_state == S_RESP) && psel_i && penable_i && !r_pslverr && r_write;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_write   <= 1'b0;
      r_cg      <= '0;
      r_prdata  <= '0;
      r_pready  <= 1'b0;
      r_pslverr <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
      if (w_setup) begin
        r_addr  <= paddr_i;
        r_write <= pwrite_i;
        r_wdata <= pwdata_i;
      end
      r_pready  <= (w_next == S_RESP);
      r_prdata  <= (w_next == S_RESP) ? w_rdata : '0;
      r_pslverr <= (w_next == S_RESP) ? w_err : 1'b0;
      if (w_commit) begin
        if (w_ca == 32'h0)      r_cg <= r_wdata[NUM_PERIPH-1:0];
        else if (w_ca == 32'h4) r_cg <= r_cg | r_wdata[NUM_PERIPH-1:0];
        else if (w_ca == 32'h8) r_cg <= r_cg & ~r_wdata[NUM_PERIPH-1:0];
      end
    end
  end

  assign prdata_o  = r_prdata;
  assign pready_o  = r_pready;
  assign pslverr_o = r_pslverr;
  assign cg_o      = r_cg;

`ifdef UDMA_APB_PROTO_CHECK_EN
  logic r_proto_err;
  logic w_busy;
  logic w_viol;

  assign w_busy = (r_state == S_WAIT) || (r_state == S_RESP);
  assign w_viol = (penable_i && !psel_i)
               || ((r_state == S_IDLE) && psel_i && penable_i)
               || (w_busy && psel_i && ((paddr_i != r_addr) || (pwrite_i != r_write) || (pwdata_i != r_wdata)))
               || (w_busy && !psel_i);

  always_ff @(posedge clk_i) begin
    if (rst_i)       r_proto_err <= 1'b0;
    else if (w_viol) r_proto_err <= 1'b1;
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk_i) begin
    if (!rst_i && w_viol) $error("udma_apb_cfg_slave: APB protocol violation");
  end
`endif

  assign proto_err_o = r_proto_err;
`else
  assign proto_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_udma_apb_cfg_slave.sv
// tb/tb_udma_apb_cfg_slave.sv - directed bench for udma_apb_cfg_slave with WAIT_CYCLES=0 and WAIT_CYCLES=3 instances.
module tb_udma_apb_cfg_slave;
  logic        clk = 1'b0;
  logic        rst[2];
  logic [31:0] paddr[2];
  logic [31:0] pwdata[2];
  logic        pwrite[2];
  logic        psel[2];
  logic        penable[2];
  logic [31:0] prdata[2];
  logic        pready[2];
  logic        pslverr[2];
  logic [7:0]  cg[2];
  logic        proto[2];

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  udma_apb_cfg_slave #(.NUM_PERIPH(8), .WAIT_CYCLES(0), .ADDR_WIDTH(12)) dut0 (
    .clk_i(clk), .rst_i(rst[0]), .paddr_i(paddr[0]), .pwdata_i(pwdata[0]), .pwrite_i(pwrite[0]),
    .psel_i(psel[0]), .penable_i(penable[0]), .prdata_o(prdata[0]), .pready_o(pready[0]),
    .pslverr_o(pslverr[0]), .cg_o(cg[0]), .proto_err_o(proto[0]));

  udma_apb_cfg_slave #(.NUM_PERIPH(8), .WAIT_CYCLES(3), .ADDR_WIDTH(12)) dut3 (
    .clk_i(clk), .rst_i(rst[1]), .paddr_i(paddr[1]), .pwdata_i(pwdata[1]), .pwrite_i(pwrite[1]),
    .psel_i(psel[1]), .penable_i(penable[1]), .prdata_o(prdata[1]), .pready_o(pready[1]),
    .pslverr_o(pslverr[1]), .cg_o(cg[1]), .proto_err_o(proto[1]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
  endtask

  // Drives one full transfer; n counts cycles from setup until pready (1 = T1).
  task automatic apb(input int d, input logic wr, input logic [31:0] a, input logic [31:0] wd,
                     output logic [31:0] rd, output logic er, output int n, output logic rdy0);
    @(negedge clk);
    rdy0 = pready[d];
    psel[d] = 1'b1; penable[d] = 1'b0; pwrite[d] = wr; paddr[d] = a; pwdata[d] = wd;
    @(negedge clk);
    penable[d] = 1'b1;
    n = 1;
    while (!pready[d] && n < 20) begin
      @(negedge clk);
      n++;
    end
    rd = prdata[d];
    er = pslverr[d];
  endtask

  task automatic idle(input int d);
    @(negedge clk);
    psel[d] = 1'b0; penable[d] = 1'b0;
  endtask

  logic [31:0] rd;
  logic        er;
  logic        rdy0;
  int          n;
  logic        exp_pe;

  initial begin
`ifdef UDMA_APB_PROTO_CHECK_EN
    exp_pe = 1'b1;
`else
    exp_pe = 1'b0;
`endif
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; paddr[d] = '0; pwdata[d] = '0; pwrite[d] = 1'b0; psel[d] = 1'b0; penable[d] = 1'b0;
    end
    repeat (3) @(negedge clk);
    rst[0] = 1'b0; rst[1] = 1'b0;
    @(negedge clk);
    chk("rst_pready", 32'(pready[0]), 32'h0);
    chk("rst_prdata", prdata[0], 32'h0);
    chk("rst_pslverr", 32'(pslverr[0]), 32'h0);
    chk("rst_cg", 32'(cg[0]), 32'h0);
    chk("rst_proto", 32'(proto[0]), 32'h0);

    // WAIT_CYCLES=0 instance
    apb(0, 1'b1, 32'h000, 32'h0000_00A5, rd, er, n, rdy0);
    chk("w0_lat", 32'(n), 32'd1);
    chk("w0_err", 32'(er), 32'h0);
    idle(0);
    chk("w0_cg", 32'(cg[0]), 32'hA5);
    apb(0, 1'b0, 32'h000, 32'h0, rd, er, n, rdy0);
    chk("r0_data", rd, 32'hA5);
    chk("r0_err", 32'(er), 32'h0);
    apb(0, 1'b1, 32'h004, 32'h0000_0002, rd, er, n, rdy0);
    idle(0);
    chk("set_cg", 32'(cg[0]), 32'hA7);
    apb(0, 1'b1, 32'h008, 32'h0000_0081, rd, er, n, rdy0);
    idle(0);
    chk("clr_cg", 32'(cg[0]), 32'h26);
    apb(0, 1'b0, 32'h004, 32'h0, rd, er, n, rdy0);
    chk("r_set_data", rd, 32'h0);
    chk("r_set_err", 32'(er), 32'h0);
    apb(0, 1'b0, 32'h008, 32'h0, rd, er, n, rdy0);
    chk("r_clr_data", rd, 32'h0);
    chk("r_clr_err", 32'(er), 32'h0);
    apb(0, 1'b0, 32'h08C, 32'h0, rd, er, n, rdy0);
    chk("id3_data", rd, 32'h3);
    chk("id3_err", 32'(er), 32'h0);
    apb(0, 1'b0, 32'h09F, 32'h0, rd, er, n, rdy0);
    chk("id7_data", rd, 32'h7);
    apb(0, 1'b1, 32'h08C, 32'hFF, rd, er, n, rdy0);
    chk("id_wr_err", 32'(er), 32'h1);
    idle(0);
    chk("id_wr_cg", 32'(cg[0]), 32'h26);
    apb(0, 1'b0, 32'h0A0, 32'h0, rd, er, n, rdy0);
    chk("unmap_err", 32'(er), 32'h1);
    chk("unmap_data", rd, 32'h0);
    apb(0, 1'b1, 32'hFFF0_0000, 32'hFFFF_FF5A, rd, er, n, rdy0);
    idle(0);
    chk("hi_bits_cg", 32'(cg[0]), 32'h5A);
    apb(0, 1'b1, 32'h000, 32'h0000_0011, rd, er, n, rdy0);
    apb(0, 1'b0, 32'h000, 32'h0, rd, er, n, rdy0);
    chk("b2b_rdy_gap", 32'(rdy0), 32'h0);
    chk("b2b_post_write", rd, 32'h11);
    idle(0);
    chk("idle_pready", 32'(pready[0]), 32'h0);

    // WAIT_CYCLES=3 instance
    apb(1, 1'b0, 32'h000, 32'h0, rd, er, n, rdy0);
    chk("w3_lat1", 32'(n), 32'd4);
    apb(1, 1'b0, 32'h000, 32'h0, rd, er, n, rdy0);
    chk("w3_one_cycle", 32'(rdy0), 32'h0);
    chk("w3_lat2", 32'(n), 32'd4);
    idle(1);
    apb(1, 1'b1, 32'h000, 32'h0000_000F, rd, er, n, rdy0);
    idle(1);
    chk("w3_cg", 32'(cg[1]), 32'h0F);

    // abort by dropping psel during WAIT
    @(negedge clk);
    psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1; paddr[1] = 32'h0; pwdata[1] = 32'hAA;
    @(negedge clk);
    penable[1] = 1'b1;
    @(negedge clk);
    psel[1] = 1'b0; penable[1] = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("abort_pready", 32'(pready[1]), 32'h0);
    end
    chk("abort_cg", 32'(cg[1]), 32'h0F);
    chk("abort_proto", 32'(proto[1]), 32'(exp_pe));

    // reset during WAIT discards the write
    @(negedge clk);
    psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1; paddr[1] = 32'h0; pwdata[1] = 32'hFF;
    @(negedge clk);
    penable[1] = 1'b1;
    @(negedge clk);
    rst[1] = 1'b1;
    @(negedge clk);
    chk("rstw_cg", 32'(cg[1]), 32'h0);
    chk("rstw_pready", 32'(pready[1]), 32'h0);
    chk("rstw_proto", 32'(proto[1]), 32'h0);
    rst[1] = 1'b0; psel[1] = 1'b0; penable[1] = 1'b0;
    apb(1, 1'b0, 32'h000, 32'h0, rd, er, n, rdy0);
    chk("rstw_read", rd, 32'h0);
    chk("rstw_read_lat", 32'(n), 32'd4);
    idle(1);

    // address changes mid-transfer
    @(negedge clk);
    psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b0; paddr[1] = 32'h0;
    @(negedge clk);
    penable[1] = 1'b1;
    @(negedge clk);
    paddr[1] = 32'h4;
    n = 0;
    while (!pready[1] && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("chg_done", 32'(n < 20), 32'h1);
    idle(1);
    chk("chg_proto", 32'(proto[1]), 32'(exp_pe));
    repeat (5) @(negedge clk);
    chk("chg_proto_sticky", 32'(proto[1]), 32'(exp_pe));
    chk("proto0_final", 32'(proto[0]), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
